// File: rtl/i2c_adc_scan_ctrl.sv
// i2c_adc_scan_ctrl: scans NUM_CH ADC channels over a byte-level I2C engine.
// For each channel it writes the config register, waits for the conversion,
// sets the pointer to the conversion register and reads the 16-bit result.
// Optional feature macro: I2C_TIMEOUT_EN adds a per-state 16-bit watchdog.
module i2c_adc_scan_ctrl #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h48,
    parameter int unsigned NUM_CH     = 4,
    parameter logic [2:0]  MUX_BASE   = 3'd4,
    parameter int unsigned CONV_WAIT  = 40000
`ifdef I2C_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  continuous,
    input  logic [7:0]            cfg_hi,
    input  logic [7:0]            cfg_lo,
    input  logic                  start_done,
    input  logic                  stop_done,
    input  logic                  write_done,
    input  logic                  ack_err,
    input  logic                  read_done,
    input  logic [7:0]            byte_r,
    output logic                  start_cond,
    output logic                  stop_cond,
    output logic                  write_byte,
    output logic [7:0]            byte_w,
    output logic                  read_byte,
    output logic                  read_last,
    output logic [16*NUM_CH-1:0]  sample,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch,
    output logic                  sample_vld,
    output logic                  scan_done,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned     CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [15:0]     CONV_LAST = 16'(CONV_WAIT - 1);
    localparam logic [7:0]      WR_ADDR   = {SLAVE_ADDR, 1'b0};
    localparam logic [7:0]      RD_ADDR   = {SLAVE_ADDR, 1'b1};

    typedef enum logic [4:0] {
        sIdle, sStartCfg, sAddrCfg, sPtrCfg, sCfgHi, sCfgLo, sStopCfg, sWaitConv,
        sStartPtr, sAddrPtr, sPtrConv, sStopPtr, sStartRd, sAddrRd, sRdHi, sRdLo,
        sStopRd, sNext, sErrStop
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [CH_W-1:0] ch;
    logic [15:0]     convCnt;
    logic [7:0]      hiByte;
    logic [7:0]      cfgHiMux;
    logic            wdExpired;

    // Config MSB with the channel's mux code spliced into bits [6:4]
    assign cfgHiMux = (cfg_hi & 8'h8F) | {1'b0, MUX_BASE + 3'(ch), 4'h0};

`ifdef I2C_TIMEOUT_EN
    logic [15:0] wdCnt;
    logic        isEngWait;

    assign isEngWait = (state != sIdle) && (state != sWaitConv) && (state != sNext);
    assign wdExpired = isEngWait && (wdCnt == 16'(TIMEOUT - 1));

    // Watchdog: restarts on every state change, counts while waiting on the engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt <= 16'd0;
        end else if ((nextState != state) || !isEngWait) begin
            wdCnt <= 16'd0;
        end else begin
            wdCnt <= wdCnt + 16'd1;
        end
    end
`else
    assign wdExpired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= sIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: each engine done pulse advances only the state waiting for it
    always_comb begin
        nextState = state;
        case (state)
            sIdle:     if (go)         nextState = sStartCfg;
            sStartCfg: if (start_done) nextState = sAddrCfg;
            sAddrCfg:  if (write_done) nextState = ack_err ? sErrStop : sPtrCfg;
            sPtrCfg:   if (write_done) nextState = ack_err ? sErrStop : sCfgHi;
            sCfgHi:    if (write_done) nextState = ack_err ? sErrStop : sCfgLo;
            sCfgLo:    if (write_done) nextState = ack_err ? sErrStop : sStopCfg;
            sStopCfg:  if (stop_done)  nextState = sWaitConv;
            sWaitConv: if (convCnt == CONV_LAST) nextState = sStartPtr;
            sStartPtr: if (start_done) nextState = sAddrPtr;
            sAddrPtr:  if (write_done) nextState = ack_err ? sErrStop : sPtrConv;
            sPtrConv:  if (write_done) nextState = ack_err ? sErrStop : sStopPtr;
            sStopPtr:  if (stop_done)  nextState = sStartRd;
            sStartRd:  if (start_done) nextState = sAddrRd;
            sAddrRd:   if (write_done) nextState = ack_err ? sErrStop : sRdHi;
            sRdHi:     if (read_done)  nextState = sRdLo;
            sRdLo:     if (read_done)  nextState = sStopRd;
            sStopRd:   if (stop_done)  nextState = sNext;
            sNext:     nextState = ((ch < LAST_CH) || continuous) ? sStartCfg : sIdle;
            sErrStop:  if (stop_done)  nextState = sIdle;
            default:   nextState = sIdle;
        endcase
        if (wdExpired) begin
            nextState = (state == sErrStop) ? sIdle : sErrStop;
        end
    end

    // Engine requests are Moore decodes of the current state
    always_comb begin
        start_cond = 1'b0;
        stop_cond  = 1'b0;
        write_byte = 1'b0;
        read_byte  = 1'b0;
        read_last  = 1'b0;
        byte_w     = 8'h00;
        busy       = (state != sIdle);
        case (state)
            sStartCfg, sStartPtr, sStartRd:        start_cond = 1'b1;
            sStopCfg, sStopPtr, sStopRd, sErrStop: stop_cond  = 1'b1;
            sAddrCfg, sAddrPtr: begin
                write_byte = 1'b1;
                byte_w     = WR_ADDR;
            end
            sPtrCfg: begin
                write_byte = 1'b1;
                byte_w     = 8'h01;
            end
            sCfgHi: begin
                write_byte = 1'b1;
                byte_w     = cfgHiMux;
            end
            sCfgLo: begin
                write_byte = 1'b1;
                byte_w     = cfg_lo;
            end
            sPtrConv: begin
                write_byte = 1'b1;
                byte_w     = 8'h00;
            end
            sAddrRd: begin
                write_byte = 1'b1;
                byte_w     = RD_ADDR;
            end
            sRdHi: read_byte = 1'b1;
            sRdLo: begin
                read_byte = 1'b1;
                read_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: channel index, conversion timer, result capture, status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch         <= '0;
            convCnt    <= 16'd0;
            hiByte     <= 8'h00;
            sample     <= '0;
            sample_ch  <= '0;
            sample_vld <= 1'b0;
            scan_done  <= 1'b0;
            error      <= 1'b0;
        end else begin
            sample_vld <= 1'b0;
            scan_done  <= 1'b0;
            convCnt    <= (state == sWaitConv) ? convCnt + 16'd1 : 16'd0;
            if ((state == sIdle) && go) begin
                error <= 1'b0;
                ch    <= '0;
            end
            if ((state != sErrStop) && (nextState == sErrStop)) begin
                error <= 1'b1;
            end
            if ((state == sErrStop) && (nextState == sIdle)) begin
                ch <= '0;
            end
            if (state == sNext) begin
                ch        <= (ch < LAST_CH) ? ch + CH_W'(1) : '0;
                scan_done <= (ch == LAST_CH);
            end
            if ((state == sRdHi) && read_done) begin
                hiByte <= byte_r;
            end
            if ((state == sRdLo) && read_done) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (ch == CH_W'(k)) begin
                        sample[16*k +: 16] <= {hiByte, byte_r};
                    end
                end
                sample_vld <= 1'b1;
                sample_ch  <= ch;
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_scan_ctrl.sv
// tb_i2c_adc_scan_ctrl: directed scenarios with a randomized engine/slave
// responder; expected bus traffic and samples come from a transaction model.
`timescale 1ns/1ps
module tb_i2c_adc_scan_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic              continuous;
    logic [7:0]        cfg_hi;
    logic [7:0]        cfg_lo;
    logic              start_done;
    logic              stop_done;
    logic              write_done;
    logic              ack_err;
    logic              read_done;
    logic [7:0]        byte_r;
    logic              start_cond;
    logic              stop_cond;
    logic              write_byte;
    logic [7:0]        byte_w;
    logic              read_byte;
    logic              read_last;
    logic [16*NCH-1:0] sample;
    logic [1:0]        sample_ch;
    logic              sample_vld;
    logic              scan_done;
    logic              busy;
    logic              error;

    i2c_adc_scan_ctrl #(.NUM_CH(NCH), .CONV_WAIT(CW)) dut (
        .clk(clk), .rst(rst), .go(go), .continuous(continuous),
        .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
        .start_done(start_done), .stop_done(stop_done), .write_done(write_done),
        .ack_err(ack_err), .read_done(read_done), .byte_r(byte_r),
        .start_cond(start_cond), .stop_cond(stop_cond), .write_byte(write_byte),
        .byte_w(byte_w), .read_byte(read_byte), .read_last(read_last),
        .sample(sample), .sample_ch(sample_ch), .sample_vld(sample_vld),
        .scan_done(scan_done), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed bus tokens: {8'h01,0}=START {8'h02,0}=STOP {8'h03,b}=WRITE b {8'h04,last}=READ
    logic [15:0] tokQ[$];
    logic [15:0] expTok[$];
    logic [7:0]  rdQ[$];
    logic [7:0]  expRd[$];
    int          convGaps[$];
    int          vldQ[$];
    logic [15:0] expS[NCH];
    int          scanDoneCnt = 0;
    int          writeCnt = 0;
    int          stopCnt = 0;
    int          nackIdx = -1;
    int          lat = 0;
    bit          measuring = 1'b0;
    int          gapCnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Engine + slave responder: random latency, NACK injection, read data from rdQ
    initial begin
        start_done = 0; stop_done = 0; write_done = 0; ack_err = 0; read_done = 0; byte_r = 0;
        forever begin
            @(negedge clk);
            start_done = 0; stop_done = 0; write_done = 0; read_done = 0; ack_err = 0;
            if (rst) begin
                lat = 0;
                measuring = 0;
            end else begin
                if (measuring) begin
                    if (start_cond) begin
                        convGaps.push_back(gapCnt);
                        measuring = 0;
                    end else begin
                        gapCnt++;
                    end
                end
                if (start_cond || stop_cond || write_byte || read_byte) begin
                    if (lat > 0) begin
                        lat--;
                    end else begin
                        lat = $urandom_range(0, 2);
                        if (start_cond) begin
                            start_done = 1;
                            tokQ.push_back(16'h0100);
                        end else if (stop_cond) begin
                            stop_done = 1;
                            tokQ.push_back(16'h0200);
                            if (stopCnt % 3 == 0) begin
                                measuring = 1;
                                gapCnt = 0;
                            end
                            stopCnt++;
                        end else if (write_byte) begin
                            write_done = 1;
                            ack_err = (writeCnt == nackIdx);
                            writeCnt++;
                            tokQ.push_back({8'h03, byte_w});
                        end else begin
                            read_done = 1;
                            byte_r = (rdQ.size() > 0) ? rdQ.pop_front() : 8'hEE;
                            tokQ.push_back({8'h04, 7'h00, read_last});
                        end
                    end
                end
            end
        end
    end

    // Output pulse monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_vld) vldQ.push_back(int'(sample_ch));
            if (scan_done) scanDoneCnt++;
        end
    end

    // Transaction model: the byte traffic one full scan must produce
    function automatic void addScan(input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] m;
        for (int c = 0; c < NCH; c++) begin
            m = (hi & 8'h8F) | 8'(((4 + c) % 8) * 16);
            expTok.push_back(16'h0100); expTok.push_back(16'h0390); expTok.push_back(16'h0301);
            expTok.push_back({8'h03, m}); expTok.push_back({8'h03, lo}); expTok.push_back(16'h0200);
            expTok.push_back(16'h0100); expTok.push_back(16'h0390); expTok.push_back(16'h0300);
            expTok.push_back(16'h0200);
            expTok.push_back(16'h0100); expTok.push_back(16'h0391); expTok.push_back(16'h0400);
            expTok.push_back(16'h0401); expTok.push_back(16'h0200);
        end
    endfunction

    // Truncate the expected traffic after the NACKed write and append the abort STOP
    function automatic void applyNack(input int at);
        logic [15:0] full[$];
        int w;
        full = expTok;
        expTok.delete();
        w = 0;
        foreach (full[i]) begin
            expTok.push_back(full[i]);
            if (full[i][15:8] == 8'h03) begin
                if (w == at) begin
                    expTok.push_back(16'h0200);
                    break;
                end
                w++;
            end
        end
    endfunction

    task automatic fillRd(input int n);
        logic [7:0] b;
        rdQ.delete();
        expRd.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            rdQ.push_back(b);
            expRd.push_back(b);
        end
    endtask

    task automatic clearLogs();
        tokQ.delete(); expTok.delete(); vldQ.delete(); convGaps.delete();
        scanDoneCnt = 0; writeCnt = 0; stopCnt = 0;
    endtask

    task automatic pulseGo();
        go = 1;
        @(negedge clk);
        go = 0;
    endtask

    task automatic waitIdle(input string tag, input int budget, input bit pokeGo);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
            go = (pokeGo && (n % 7 == 3) && busy === 1'b1);
        end
        go = 0;
        chk({tag, "_idle_in_budget"}, 64'(n < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmpTokens(input string tag);
        chk({tag, "_ntok"}, 64'(tokQ.size()), 64'(expTok.size()));
        for (int i = 0; i < expTok.size() && i < tokQ.size(); i++)
            chk($sformatf("%s_tok%0d", tag, i), 64'(tokQ[i]), 64'(expTok[i]));
    endtask

    task automatic cmpSamples(input string tag);
        logic [16*NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[16*c +: 16] = expS[c];
        chk({tag, "_sample"}, 64'(sample), 64'(e));
    endtask

    task automatic cmpVld(input string tag, input int nScans, input int nCh);
        chk({tag, "_nvld"}, 64'(vldQ.size()), 64'(nScans * nCh));
        for (int i = 0; i < vldQ.size() && i < nScans * nCh; i++)
            chk($sformatf("%s_vld%0d", tag, i), 64'(vldQ[i]), 64'(i % nCh));
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        int n;
        rst = 1; go = 0; continuous = 0; cfg_hi = 8'h00; cfg_lo = 8'h00;
        for (int c = 0; c < NCH; c++) expS[c] = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(start_cond), 64'd0);
        chk("rst_stop", 64'(stop_cond), 64'd0);
        chk("rst_write", 64'(write_byte), 64'd0);
        chk("rst_read", 64'(read_byte), 64'd0);
        chk("rst_byte_w", 64'(byte_w), 64'd0);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        rst = 0;
        @(negedge clk);

        // Scan with random config, extra go pulses while busy must be ignored
        hi = 8'($urandom); lo = 8'($urandom);
        cfg_hi = hi; cfg_lo = lo;
        clearLogs(); fillRd(2 * NCH); addScan(hi, lo);
        pulseGo();
        chk("a_busy_after_go", 64'(busy), 64'd1);
        waitIdle("a", 3000, 1'b1);
        for (int c = 0; c < NCH; c++) expS[c] = {expRd[2*c], expRd[2*c+1]};
        cmpTokens("a");
        cmpSamples("a");
        cmpVld("a", 1, NCH);
        chk("a_scan_done", 64'(scanDoneCnt), 64'd1);
        chk("a_error", 64'(error), 64'd0);
        chk("a_ngaps", 64'(convGaps.size()), 64'(NCH));
        foreach (convGaps[i]) chk($sformatf("a_gap%0d", i), 64'(convGaps[i]), 64'(CW));

        // cfg_hi=C3: mux field walks 4..7 across channels
        cfg_hi = 8'hC3; cfg_lo = 8'h83;
        clearLogs(); fillRd(2 * NCH); addScan(8'hC3, 8'h83);
        pulseGo();
        waitIdle("b", 3000, 1'b0);
        for (int c = 0; c < NCH; c++) expS[c] = {expRd[2*c], expRd[2*c+1]};
        cmpTokens("b");
        cmpSamples("b");
        cmpVld("b", 1, NCH);
        chk("b_cfg_ch0", 64'(tokQ[3]), 64'h03C3);
        chk("b_cfg_ch1", 64'(tokQ[18]), 64'h03D3);
        chk("b_cfg_ch2", 64'(tokQ[33]), 64'h03E3);
        chk("b_cfg_ch3", 64'(tokQ[48]), 64'h03F3);

        // NACK on ADDR_PTR of ch2 (7 writes per channel, 5th of the channel)
        hi = 8'($urandom); lo = 8'($urandom);
        cfg_hi = hi; cfg_lo = lo;
        clearLogs(); fillRd(2 * NCH); addScan(hi, lo);
        nackIdx = 2 * 7 + 4;
        applyNack(nackIdx);
        pulseGo();
        waitIdle("c", 3000, 1'b0);
        nackIdx = -1;
        for (int c = 0; c < 2; c++) expS[c] = {expRd[2*c], expRd[2*c+1]};
        cmpTokens("c");
        cmpSamples("c");
        cmpVld("c", 1, 2);
        chk("c_error", 64'(error), 64'd1);
        chk("c_busy", 64'(busy), 64'd0);
        chk("c_scan_done", 64'(scanDoneCnt), 64'd0);
        clearLogs(); fillRd(2 * NCH); addScan(hi, lo);
        pulseGo();
        chk("c_error_cleared", 64'(error), 64'd0);
        waitIdle("c2", 3000, 1'b0);
        for (int c = 0; c < NCH; c++) expS[c] = {expRd[2*c], expRd[2*c+1]};
        cmpTokens("c2");
        cmpSamples("c2");
        chk("c2_scan_done", 64'(scanDoneCnt), 64'd1);

        // Continuous for two scans, then dropped: third scan completes, then idle
        hi = 8'($urandom); lo = 8'($urandom);
        cfg_hi = hi; cfg_lo = lo;
        clearLogs(); fillRd(6 * NCH);
        addScan(hi, lo); addScan(hi, lo); addScan(hi, lo);
        continuous = 1;
        pulseGo();
        n = 0;
        while (scanDoneCnt < 2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("d_two_scans_in_budget", 64'(n < 6000), 64'd1);
        continuous = 0;
        waitIdle("d", 3000, 1'b0);
        for (int c = 0; c < NCH; c++) expS[c] = {expRd[16 + 2*c], expRd[16 + 2*c + 1]};
        cmpTokens("d");
        cmpSamples("d");
        cmpVld("d", 3, NCH);
        chk("d_scan_done", 64'(scanDoneCnt), 64'd3);
        chk("d_busy", 64'(busy), 64'd0);

        // Reset while in RD_HI returns every output to its reset value at once
        clearLogs(); fillRd(2 * NCH);
        pulseGo();
        n = 0;
        while (!(read_byte === 1'b1 && read_last === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("e_reach_rdhi", 64'(n < 3000), 64'd1);
        rst = 1;
        #1;
        chk("e_busy", 64'(busy), 64'd0);
        chk("e_read", 64'(read_byte), 64'd0);
        chk("e_start", 64'(start_cond), 64'd0);
        chk("e_stop", 64'(stop_cond), 64'd0);
        chk("e_write", 64'(write_byte), 64'd0);
        chk("e_byte_w", 64'(byte_w), 64'd0);
        chk("e_sample", 64'(sample), 64'd0);
        chk("e_sample_ch", 64'(sample_ch), 64'd0);
        chk("e_vld", 64'(sample_vld), 64'd0);
        chk("e_scan_done", 64'(scan_done), 64'd0);
        chk("e_error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("e_stays_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
